// File: rtl/ihex_loader_if.sv
// Loader bus: console character stream in, single-byte memory write strobes out.
interface ihex_loader_if #(parameter int ADDR_WIDTH = 16);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;

  modport master (input rx_valid, rx_data, output wr_en, wr_addr, wr_data);
  modport slave  (output rx_valid, rx_data, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ihex_loader.sv
// Intel-HEX record parser driving memory write strobes; holds the CPU via busy.
// Optional build macro IHEX_CSUM_EN enables record checksum verification.
module ihex_loader #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ihex_loader_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rec_count
);
  typedef enum logic [2:0] {IDLE, LEN, ADDR_HI, ADDR_LO, TYPE, DATA, CSUM} state_t;

  localparam logic [7:0] COLON = 8'h3A;

  state_t      state;
  logic        lo;        // high nibble captured, next hex char completes the byte
  logic [3:0]  hi_nib;
  logic [7:0]  cnt;
  logic [15:0] addr;
  logic [7:0]  rtype;

  logic        is_hex;
  logic [3:0]  nib;
  logic [7:0]  byte_val;
  logic        csum_bad;

  // 'A'-'F' and 'a'-'f' share the low nibble 1..6, so +9 maps them to 10..15
  always_comb begin
    is_hex = 1'b1;
    nib    = bus.rx_data[3:0];
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39)
      nib = bus.rx_data[3:0];
    else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
             (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66))
      nib = bus.rx_data[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  assign byte_val = {hi_nib, nib};

`ifdef IHEX_CSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + byte_val;
  assign csum_bad = (sum_next != 8'h00);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lo          <= 1'b0;
      hi_nib      <= '0;
      cnt         <= '0;
      addr        <= '0;
      rtype       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rec_count   <= '0;
`ifdef IHEX_CSUM_EN
      sum         <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      if (bus.rx_valid) begin
        if (state == IDLE) begin
          if (bus.rx_data == COLON) begin
            busy <= 1'b1;
            if (!busy) begin
              err       <= 1'b0;
              rec_count <= '0;
            end
`ifdef IHEX_CSUM_EN
            sum <= '0;
`endif
            lo    <= 1'b0;
            state <= LEN;
          end
        end else if (bus.rx_data == COLON) begin
          // resync on a stray start code; keep the CPU paused
          err   <= 1'b1;
          lo    <= 1'b0;
          state <= LEN;
`ifdef IHEX_CSUM_EN
          sum <= '0;
`endif
        end else if (!is_hex) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          lo    <= 1'b0;
          state <= IDLE;
        end else if (!lo) begin
          hi_nib <= nib;
          lo     <= 1'b1;
        end else begin
          lo <= 1'b0;
`ifdef IHEX_CSUM_EN
          sum <= sum_next;
`endif
          case (state)
            LEN: begin
              cnt   <= byte_val;
              state <= ADDR_HI;
            end
            ADDR_HI: begin
              addr[15:8] <= byte_val;
              state      <= ADDR_LO;
            end
            ADDR_LO: begin
              addr[7:0] <= byte_val;
              state     <= TYPE;
            end
            TYPE: begin
              rtype <= byte_val;
              state <= (cnt == 8'd0) ? CSUM : DATA;
            end
            DATA: begin
              if (rtype == 8'h00) begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= ADDR_WIDTH'(addr);
                bus.wr_data <= byte_val;
                addr        <= addr + 16'd1;
              end
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) state <= CSUM;
            end
            CSUM: begin
              if (rec_count != 8'hFF) rec_count <= rec_count + 8'd1;
              state <= IDLE;
              // any error in the record releases the CPU instead of completing
              if (err || csum_bad) begin
                err  <= 1'b1;
                busy <= 1'b0;
              end else if (rtype == 8'h01) begin
                done <= 1'b1;
                busy <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/ihex_loader.md
# ihex_loader

Serial Intel-HEX loader that sits upstream of the Altair core's memory and front-panel deposit path. It consumes the ASCII byte stream from the console UART receiver, parses Intel-HEX records and issues single-byte memory write strobes. While a load is in progress it holds the CPU paused, so a program image can be loaded into main RAM or stack RAM without using the DEPOSIT / DEPOSIT NEXT switches. Its write port is OR-merged into the core's deposit write path; address decoding stays in the core.

## Interface
Parameters
- `ADDR_WIDTH`, default 16: width of `wr_addr`. Record addresses are truncated to this width.

Ports
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a received character.
- `rx_data` in 8: ASCII character.
- `wr_en` out 1: one-cycle memory write strobe.
- `wr_addr` out ADDR_WIDTH: write address, valid while `wr_en` is high.
- `wr_data` out 8: write data, valid while `wr_en` is high.
- `busy` out 1: load in progress; the core ORs this into pause.
- `done` out 1: one-cycle pulse on successful completion of an EOF record.
- `err` out 1: sticky error flag.
- `rec_count` out 8: count of records completed since load start; saturates at 0xFF.

## Operation
- States: IDLE, LEN, ADDR_HI, ADDR_LO, TYPE, DATA, CSUM.
- Each field byte is two hex characters.
  - Hex digits 0-9, A-F and a-f are accepted.
  - A nibble flag selects the high or low half.
- ':' in IDLE:
  - Sets `busy`.
  - Clears `err` and `rec_count`, but only if `busy` was 0.
  - Sum := 0; next state LEN.
- Every completed byte is added to the 8-bit running sum, modulo 256.
- LEN is stored as remaining count. ADDR_HI then ADDR_LO load the address register. TYPE is stored.
- After TYPE:
  - Count 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Type 00: each completed byte pulses `wr_en` with the current address and the byte, then the address increments with wrap-around (0xFFFF→0x0000).
  - Any other type: no write.
  - The count decrements; at 0 → CSUM.
- CSUM: the record checksum is checked (see Configuration), `rec_count` increments, and the state returns to IDLE.
  - If type = 01 and no error: pulse `done` and clear `busy`.
- CR, LF and space received in IDLE are ignored. Any other non-':' character in IDLE is ignored.
- Non-hex character inside a record:
  - Sets `err`, clears `busy`, state → IDLE.
  - The partial byte is discarded.
- ':' inside a record: sets `err`, then restarts the record (state LEN, sum cleared), and `busy` stays 1.
- Data is written as it arrives. A bad checksum does not roll back writes that already happened.
- An error in any record clears `busy` at that record's end, so the CPU is not held forever.
- Reset mid-record: all state is cleared immediately and no further writes occur.

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `done`=0, `err`=0, `rec_count`=0.
  - State IDLE.
- All outputs are registered.
- `wr_en` rises on the cycle after the `rx_valid` that carries the low-nibble character of a data byte, and stays high for exactly one cycle.
- `done`, the clearing of `busy`, and the setting of `err` all take effect on the cycle after the final checksum character.
- `rx_valid` may be asserted on back-to-back cycles; every strobe is accepted. There is no backpressure.
- If `rx_valid` is high during reset, it is ignored.

## Configuration
- `IHEX_CSUM_EN` defined:
  - At CSUM, a nonzero sum (all bytes including the checksum, mod 256) sets `err`.
  - On an EOF record, this suppresses `done` and clears `busy`.
- `IHEX_CSUM_EN` not defined:
  - The checksum byte is parsed and discarded. No sum adder is built.
  - `err` is set only by framing errors: non-hex character, or ':' inside a record.

## Test plan
- ":03001000010203E7" → writes 0x0010=01, 0x0011=02, 0x0012=03; `err`=0; `busy`=1; `rec_count`=1.
- Then ":00000001FF" → `done` pulses once, `busy`→0, `rec_count`=2.
- ":02FFFF00AABB9B" → writes 0xFFFF=AA, then 0x0000=BB (wrap-around); no error.
- ":03001000010203E8" with `IHEX_CSUM_EN` defined → three writes still occur, `err`=1, `busy`=0.
  - Same stream without the macro → `err`=0.
- ":0300G0" → `err`=1 on 'G', `busy`=0, no writes.
  - A following ":00000001FF" clears `err` and pulses `done`.
- Drop `rst_n` after ":03001000" plus "01" → `wr_en` is held low from reset onward, all outputs return to 0, and the trailing "0203E7" produces no writes.
